// File: rtl/mem_port_if.sv
// Request/response and clear-control bundle between the CPU side and mem_port_ctrl.
`timescale 1ns/1ps
interface mem_port_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              clr_start;
  logic              clr_busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, clr_start,
    input  req_ready, rsp_valid, rsp_rdata, clr_busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, clr_start,
    output req_ready, rsp_valid, rsp_rdata, clr_busy
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Front-end for the data RAM: posted-write FIFO, one-cycle reads, and a zero-fill sweep
// that runs after reset or on request.
`timescale 1ns/1ps
module mem_port_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 4096,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_if.slave         bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] wbuf_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] wbuf_data [WBUF_DEPTH];
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic [ADDR_W-1:0] last_addr_reg;

  logic empty, full, push, pop, rd_acc;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(WBUF_DEPTH));

  // Reads wait for an empty buffer so a read never overtakes a posted write.
  assign bus.req_ready = rst_n && (state_reg == ST_RUN) && !bus.clr_start &&
                         (bus.req_we ? !full : empty);
  assign push   = bus.req_valid && bus.req_ready && bus.req_we;
  assign rd_acc = bus.req_valid && bus.req_ready && !bus.req_we;
  assign pop    = rst_n && (state_reg != ST_CLEAR) && !empty;

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.clr_busy  = !rst_n || (state_reg != ST_RUN);

  always_comb begin
    ram_addr = last_addr_reg;
    ram_in   = '0;
    ram_load = 1'b0;
    if (!rst_n) begin
      ram_addr = '0;
    end else if (state_reg == ST_CLEAR) begin
      ram_addr = cnt_reg;
      ram_load = 1'b1;
    end else if (!empty) begin
      ram_addr = wbuf_addr[rd_ptr_reg];
      ram_in   = wbuf_data[rd_ptr_reg];
      ram_load = 1'b1;
    end else if (rd_acc) begin
      ram_addr = bus.req_addr;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        cnt_next = cnt_reg + ADDR_W'(1);
        if (cnt_reg == ADDR_W'(DEPTH - 1)) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (bus.clr_start) begin
          if (empty) begin
            state_next = ST_CLEAR;
            cnt_next   = '0;
          end else begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Empty check also covers a drain entered while its last entry was leaving.
        if (empty || (pop && count_reg == CNT_W'(1))) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_CLEAR;
      cnt_reg       <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      last_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      last_addr_reg <= ram_addr;
      rsp_valid_reg <= rd_acc;
      if (rd_acc) rsp_rdata_reg <= ram_out;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wbuf_addr[wr_ptr_reg] <= bus.req_addr;
      wbuf_data[wr_ptr_reg] <= bus.req_wdata;
    end
  end
endmodule
